demux_4_tdm: RTL and testbench
==============================

# demux_4_tdm

Time-division demultiplexer: the receive-side counterpart of the team's 4:1 selector. A single WIDTH-bit stream carries frames of four words, slot 0 to slot 3, with slot 0 flagged by a start-of-frame marker. The block tracks frame alignment, collects the four slots in shadow registers, and publishes all four atomically to the parallel outputs q0..q3 when a frame completes. It sits at the far end of a serialized link, restoring the four parallel buses that fed the mux.

## Interface
- WIDTH, 4, data width of each slot and each output bus
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data, in_sof (and in_par) carry a word this cycle
- in_sof  input  1  start of frame; qualified by in_valid; marks slot 0
- in_data  input  WIDTH  slot word
- in_par  input  1  even parity over in_data (only with DEMUX4_PARITY_EN)
- q0, q1, q2, q3  output  WIDTH each  registered slot 0..3 of the last good frame
- frame_valid  output  1  one-cycle pulse: q0..q3 just updated
- sync_err  output  1  one-cycle pulse: framing violation detected
- locked  output  1  high while in RECV state
- par_err  output  1  one-cycle pulse: parity mismatch (only with DEMUX4_PARITY_EN)

## Operation
- Reset (asynchronous, active-low):
  - Outputs: q0..q3=0, frame_valid=0, sync_err=0, par_err=0, locked=0.
  - Internal: state=HUNT, slot=0, shadow registers=0, bad-frame flag=0.
- Cycles with in_valid=0 are bubbles: no state, slot or shadow change, and all pulses are low.

HUNT state:
- in_valid=1 and in_sof=1: shadow0<=in_data, slot<=1, go to RECV.
- in_valid=1 and in_sof=0: word dropped, stay in HUNT, no error pulse.

RECV state, slot 0:
- in_valid=1 and in_sof=1: shadow0<=in_data, slot<=1.
- in_valid=1 and in_sof=0: sync_err pulse, word dropped, go to HUNT, slot<=0.

RECV state, slot 1 or 2:
- in_valid=1 and in_sof=0: shadow[slot]<=in_data, slot<=slot+1.

RECV state, slot 3:
- in_valid=1 and in_sof=0:
  - q0<=shadow0, q1<=shadow1, q2<=shadow2, q3<=in_data, frame_valid pulse.
  - slot wraps to 0; state stays RECV.

Early start of frame (RECV, slot 1..3, in_valid=1, in_sof=1):
- sync_err pulse; the partial frame is discarded and q0..q3 are held.
- The word is taken as a new slot 0: shadow0<=in_data, slot<=1.

Other rules:
- q0..q3 change only on a frame_valid edge; a partial frame never reaches them.
- locked equals (state==RECV).

## Timing
- Latency: q0..q3 and frame_valid are updated on the rising edge that samples the slot-3 word. They are visible in the next cycle.
- frame_valid and sync_err are single-cycle registered pulses; they are never asserted together.
- Minimum frame: 4 consecutive valid cycles. Back-to-back frames yield a frame_valid pulse every 4 cycles.
- Reset mid-frame clears everything immediately; after deassertion the block resumes in HUNT.

## Configuration
- Macro: DEMUX4_PARITY_EN.
- Defined:
  - The in_par input and par_err output exist.
  - On each accepted word (any state transition that stores or publishes it), if ^in_data != in_par: par_err pulses and the bad-frame flag is set.
  - At slot 3, if the flag (or a mismatch on the slot-3 word) is set, q0..q3 are held and frame_valid stays low. The flag clears at the slot-3 word or at any new slot 0.
  - Framing is unaffected by parity errors.
- Undefined: in_par and par_err ports are absent; no parity logic.

## Test plan
- Reset, then words 3(sof),4,8,2 on 4 consecutive cycles -> q0=3, q1=4, q2=8, q3=2, frame_valid high exactly one cycle, locked=1.
- Same frame with 2 bubble cycles between slots 1 and 2 -> identical q values; frame_valid 2 cycles later than the gapless case.
- After a good frame, send 5(sof),6 then 7(sof),1,2,9 -> sync_err one pulse on the 7(sof) word, q unchanged until it becomes 7,1,2,9 with frame_valid.
- Send 5 without sof at slot 0 while locked -> sync_err pulse, locked=0; the next non-sof words are ignored until the next sof.
- Assert rst_n=0 after slot 2 of a frame -> all outputs 0 asynchronously, locked=0; the following frame 1(sof),2,3,4 is received correctly.
- With DEMUX4_PARITY_EN, corrupt in_par on slot 1 of frame A(sof),B,C,D -> par_err pulse, no frame_valid, q held; the next clean frame publishes normally.

Source files
------------

// File: rtl/demux_4_tdm_if.sv
// rtl/demux_4_tdm_if.sv - slot stream in, parallel frame out; DEMUX4_PARITY_EN adds in_par/par_err
interface demux_4_tdm_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_sof;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q3;
    logic             frame_valid;
    logic             sync_err;
    logic             locked;
`ifdef DEMUX4_PARITY_EN
    logic             in_par;
    logic             par_err;

    modport master (
        output in_valid, in_sof, in_data, in_par,
        input  q0, q1, q2, q3, frame_valid, sync_err, locked, par_err
    );
    modport slave (
        input  in_valid, in_sof, in_data, in_par,
        output q0, q1, q2, q3, frame_valid, sync_err, locked, par_err
    );
`else
    modport master (
        output in_valid, in_sof, in_data,
        input  q0, q1, q2, q3, frame_valid, sync_err, locked
    );
    modport slave (
        input  in_valid, in_sof, in_data,
        output q0, q1, q2, q3, frame_valid, sync_err, locked
    );
`endif
endinterface

// File: rtl/demux_4_tdm.sv
// rtl/demux_4_tdm.sv - 4-slot TDM demultiplexer with frame alignment and atomic publish
// Optional even-parity checking on accepted words when DEMUX4_PARITY_EN is defined.
module demux_4_tdm #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    demux_4_tdm_if.slave bus
);

    typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [WIDTH-1:0] q0_q, q0_d, q1_q, q1_d, q2_q, q2_d, q3_q, q3_d;
    logic             fv_q, fv_d;
    logic             se_q, se_d;

    logic take_sof;
    logic take_mid;
    logic frame_bad;

    // take_mid covers non-sof words landing in slots 1..3 of an aligned frame
    assign take_sof = bus.in_valid && bus.in_sof;
    assign take_mid = bus.in_valid && !bus.in_sof && (state_q == RECV) && (slot_q != 2'd0);

`ifdef DEMUX4_PARITY_EN
    logic pe_q, pe_d;
    logic bad_q, bad_d;
    logic par_mis;

    assign par_mis   = (^bus.in_data) != bus.in_par;
    assign frame_bad = bad_q || par_mis;

    always_comb begin
        pe_d  = (take_sof || take_mid) && par_mis;
        bad_d = bad_q;
        if (take_sof) begin
            bad_d = par_mis;
        end else if (take_mid) begin
            bad_d = (slot_q == 2'd3) ? 1'b0 : (bad_q || par_mis);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_q  <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            pe_q  <= pe_d;
            bad_q <= bad_d;
        end
    end

    assign bus.par_err = pe_q;
`else
    assign frame_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            q0_q    <= '0;
            q1_q    <= '0;
            q2_q    <= '0;
            q3_q    <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            q3_q    <= q3_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.in_sof) begin
                        state_d = RECV;
                        slot_d  = 2'd1;
                    end
                end
                RECV: begin
                    if (bus.in_sof) begin
                        slot_d = 2'd1;
                    end else if (slot_q == 2'd0) begin
                        state_d = HUNT;
                        slot_d  = 2'd0;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        sh0_d = sh0_q;
        sh1_d = sh1_q;
        sh2_d = sh2_q;
        q0_d  = q0_q;
        q1_d  = q1_q;
        q2_d  = q2_q;
        q3_d  = q3_q;
        fv_d  = 1'b0;
        // sof off slot 0, or a missing sof at slot 0, breaks alignment
        se_d  = bus.in_valid && (state_q == RECV) &&
                (bus.in_sof ? (slot_q != 2'd0) : (slot_q == 2'd0));
        if (take_sof) begin
            sh0_d = bus.in_data;
        end
        if (take_mid && (slot_q == 2'd1)) begin
            sh1_d = bus.in_data;
        end
        if (take_mid && (slot_q == 2'd2)) begin
            sh2_d = bus.in_data;
        end
        if (take_mid && (slot_q == 2'd3) && !frame_bad) begin
            q0_d = sh0_q;
            q1_d = sh1_q;
            q2_d = sh2_q;
            q3_d = bus.in_data;
            fv_d = 1'b1;
        end
    end

    assign bus.q0          = q0_q;
    assign bus.q1          = q1_q;
    assign bus.q2          = q2_q;
    assign bus.q3          = q3_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.locked      = (state_q == RECV);

endmodule

// File: tb/tb_demux_4_tdm.sv
// tb/tb_demux_4_tdm.sv - vector table, corner sequences and random run against a frame-queue model
module tb_demux_4_tdm;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_4_tdm_if #(.WIDTH(W)) bus ();
    demux_4_tdm #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          v;
        bit          sof;
        logic [3:0]  d;
        bit          fv;
        bit          se;
        bit          lk;
        logic [15:0] q;
    } vec_t;

    vec_t tbl[$];

    // Model: words since the last sof held in a queue; a frame is published at four.
    logic [W-1:0] fbuf[$];
    logic [W-1:0] m_q[4];
    bit           m_locked, m_bad, m_fv, m_se, m_pe;

    function automatic vec_t mk(bit v, bit sof, logic [3:0] d, bit fv, bit se, bit lk, logic [15:0] q);
        vec_t r;
        r.v = v; r.sof = sof; r.d = d; r.fv = fv; r.se = se; r.lk = lk; r.q = q;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit sof, input logic [W-1:0] d, input bit badpar);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_data  = d;
`ifdef DEMUX4_PARITY_EN
        bus.in_par   = (^d) ^ badpar;
`endif
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] qcat();
        return {bus.q0, bus.q1, bus.q2, bus.q3};
    endfunction

    task automatic model_reset();
        fbuf.delete();
        for (int i = 0; i < 4; i++) m_q[i] = '0;
        m_locked = 0; m_bad = 0; m_fv = 0; m_se = 0; m_pe = 0;
    endtask

    task automatic model_step(input bit v, input bit sof, input logic [W-1:0] d, input bit badpar);
        bit acc;
        acc = 0; m_fv = 0; m_se = 0; m_pe = 0;
        if (v) begin
            if (sof) begin
                if (m_locked && fbuf.size() != 0) m_se = 1;
                fbuf.delete();
                fbuf.push_back(d);
                m_locked = 1; m_bad = 0; acc = 1;
            end else if (m_locked) begin
                if (fbuf.size() == 0) begin
                    m_se = 1; m_locked = 0;
                end else begin
                    fbuf.push_back(d); acc = 1;
                end
            end
`ifdef DEMUX4_PARITY_EN
            if (acc && badpar) begin m_pe = 1; m_bad = 1; end
`endif
            if (fbuf.size() == 4) begin
                if (!m_bad) begin
                    for (int i = 0; i < 4; i++) m_q[i] = fbuf[i];
                    m_fv = 1;
                end
                fbuf.delete();
                m_bad = 0;
            end
        end
    endtask

    task automatic step_model(input string tag, input bit v, input bit sof, input logic [W-1:0] d, input bit badpar);
        drive(v, sof, d, badpar);
        model_step(v, sof, d, badpar);
        chk({tag, " frame_valid"}, bus.frame_valid, m_fv);
        chk({tag, " sync_err"}, bus.sync_err, m_se);
        chk({tag, " locked"}, bus.locked, m_locked);
        chk({tag, " q"}, qcat(), {m_q[0], m_q[1], m_q[2], m_q[3]});
`ifdef DEMUX4_PARITY_EN
        chk({tag, " par_err"}, bus.par_err, m_pe);
`endif
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_sof   = 0;
        bus.in_data  = '0;
`ifdef DEMUX4_PARITY_EN
        bus.in_par   = 0;
`endif
        model_reset();

        tbl.push_back(mk(1, 1, 4'h3, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 4'h4, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 4'h8, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 4'h2, 1, 0, 1, 16'h3482));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(1, 1, 4'h3, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(1, 0, 4'h4, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(0, 1, 4'hF, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(1, 0, 4'h8, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(1, 0, 4'h2, 1, 0, 1, 16'h3482));
        tbl.push_back(mk(1, 1, 4'h5, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(1, 0, 4'h6, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(1, 1, 4'h7, 0, 1, 1, 16'h3482));
        tbl.push_back(mk(1, 0, 4'h1, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(1, 0, 4'h2, 0, 0, 1, 16'h3482));
        tbl.push_back(mk(1, 0, 4'h9, 1, 0, 1, 16'h7129));
        tbl.push_back(mk(1, 0, 4'h5, 0, 1, 0, 16'h7129));
        tbl.push_back(mk(1, 0, 4'h6, 0, 0, 0, 16'h7129));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, 0, 16'h7129));
        tbl.push_back(mk(1, 1, 4'hA, 0, 0, 1, 16'h7129));
        tbl.push_back(mk(1, 0, 4'hB, 0, 0, 1, 16'h7129));
        tbl.push_back(mk(1, 0, 4'hC, 0, 0, 1, 16'h7129));
        tbl.push_back(mk(1, 0, 4'hD, 1, 0, 1, 16'hABCD));

        repeat (3) @(negedge clk);
        #1;
        chk("reset q", qcat(), 16'h0000);
        chk("reset frame_valid", bus.frame_valid, 1'b0);
        chk("reset sync_err", bus.sync_err, 1'b0);
        chk("reset locked", bus.locked, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].sof, tbl[i].d, 1'b0);
            chk($sformatf("vec%0d frame_valid", i), bus.frame_valid, tbl[i].fv);
            chk($sformatf("vec%0d sync_err", i), bus.sync_err, tbl[i].se);
            chk($sformatf("vec%0d locked", i), bus.locked, tbl[i].lk);
            chk($sformatf("vec%0d q", i), qcat(), tbl[i].q);
`ifdef DEMUX4_PARITY_EN
            chk($sformatf("vec%0d par_err", i), bus.par_err, 1'b0);
`endif
        end

`ifdef DEMUX4_PARITY_EN
        drive(1, 1, 4'h1, 0);
        chk("par good sof par_err", bus.par_err, 1'b0);
        drive(1, 0, 4'h2, 1);
        chk("par bad slot1 par_err", bus.par_err, 1'b1);
        drive(1, 0, 4'h3, 0);
        chk("par slot2 par_err", bus.par_err, 1'b0);
        drive(1, 0, 4'h4, 0);
        chk("par bad frame frame_valid", bus.frame_valid, 1'b0);
        chk("par bad frame q held", qcat(), 16'hABCD);
        chk("par bad frame locked", bus.locked, 1'b1);
        drive(1, 1, 4'h5, 0);
        drive(1, 0, 4'h6, 0);
        drive(1, 0, 4'h7, 0);
        drive(1, 0, 4'h8, 0);
        chk("par clean frame frame_valid", bus.frame_valid, 1'b1);
        chk("par clean frame q", qcat(), 16'h5678);
`endif

        // Abort mid-frame with an asynchronous reset between clock edges.
        drive(1, 1, 4'h1, 0);
        drive(1, 0, 4'h2, 0);
        drive(1, 0, 4'h3, 0);
        @(negedge clk);
        bus.in_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset q", qcat(), 16'h0000);
        chk("async reset locked", bus.locked, 1'b0);
        chk("async reset frame_valid", bus.frame_valid, 1'b0);
        chk("async reset sync_err", bus.sync_err, 1'b0);
`ifdef DEMUX4_PARITY_EN
        chk("async reset par_err", bus.par_err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step_model("post reset w0", 1, 1, 4'h1, 0);
        step_model("post reset w1", 1, 0, 4'h2, 0);
        step_model("post reset w2", 1, 0, 4'h3, 0);
        step_model("post reset w3", 1, 0, 4'h4, 0);
        chk("post reset q", qcat(), 16'h1234);
        chk("post reset frame_valid", bus.frame_valid, 1'b1);

        begin
            int gen_slot;
            bit v, sof, bp;
            logic [W-1:0] d;
            gen_slot = 0;
            for (int n = 0; n < 600; n++) begin
                v   = ($urandom_range(0, 3) != 0);
                sof = ($urandom_range(0, 11) == 0) ? bit'($urandom_range(0, 1)) : (gen_slot == 0);
                d   = W'($urandom_range(0, (1 << W) - 1));
                bp  = ($urandom_range(0, 15) == 0);
                if (v) gen_slot = sof ? 1 : (gen_slot + 1) % 4;
                step_model($sformatf("rand%0d", n), v, sof, d, bp);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
